ex_sat_stage: RTL and testbench

EX_SAT_STAGE -- requirements
Module: ex_sat_stage

---
 rtl/ex_sat_stage.sv | 112 +++++++++++
 tb/tb_ex_sat_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ex_sat_stage.sv
// ex_sat_stage: single-cycle execute stage with a 16-bit signed saturating
// ALU (ADD/SUB/XOR/PASSB), registered result, valid bit and Z/V/N flags.
// Supports stall (hold everything) and flush (squash the capture, flush
// wins over stall).
module ex_sat_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [1:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        stall,
  input  logic        flush,
  output logic        out_valid,
  output logic [15:0] result,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
);

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_XOR   = 2'b10,
    OP_PASSB = 2'b11
  } op_e;

  op_e         op_sel;
  logic        is_sub;
  logic [15:0] b_eff;
  logic [15:0] raw_sum;
  logic        arith_ovf;
  logic [15:0] sat_sum;
  logic [15:0] xor_val;

  logic        out_valid_d, out_valid_q;
  logic [15:0] result_d,    result_q;
  logic        flag_z_d,    flag_z_q;
  logic        flag_v_d,    flag_v_q;
  logic        flag_n_d,    flag_n_q;

  assign op_sel = op_e'(op);

  // Adder datapath: SUB is a + ~b + 1, overflow judged from the signs of the
  // two adder operands against the raw sum, then clamped to the signed range.
  always_comb begin
    is_sub    = (op_sel == OP_SUB);
    b_eff     = is_sub ? ~b : b;
    raw_sum   = a + b_eff + {15'b0, is_sub};
    arith_ovf = (a[15] == b_eff[15]) && (raw_sum[15] != a[15]);
    sat_sum   = arith_ovf ? (a[15] ? 16'h8000 : 16'h7FFF) : raw_sum;
    xor_val   = a ^ b;
  end

  // Next-state selection: flush squashes, stall holds, otherwise capture or bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flag_z_d    = flag_z_q;
    flag_v_d    = flag_v_q;
    flag_n_d    = flag_n_q;
    if (flush) begin
      out_valid_d = 1'b0;
      result_d    = '0;
    end else if (!stall) begin
      if (!in_valid) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = 1'b1;
        unique case (op_sel)
          OP_ADD, OP_SUB: begin
            result_d = sat_sum;
            flag_z_d = (sat_sum == 16'h0000);
            flag_n_d = sat_sum[15];
            flag_v_d = arith_ovf;
          end
          OP_XOR: begin
            result_d = xor_val;
            flag_z_d = (xor_val == 16'h0000);
          end
          OP_PASSB: begin
            result_d = b;
          end
        endcase
      end
    end
  end

  // Pipeline register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flag_z_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_n_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flag_z_q    <= flag_z_d;
      flag_v_q    <= flag_v_d;
      flag_n_q    <= flag_n_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_v    = flag_v_q;
  assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_ex_sat_stage.sv
// tb_ex_sat_stage: directed and randomized checks of ex_sat_stage against an
// arithmetic reference model (true signed sum/difference, then clamp).
module tb_ex_sat_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [15:0] result;
  logic        flag_z, flag_v, flag_n;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // reference model state
  logic        m_valid = 1'b0;
  logic [15:0] m_result = '0;
  logic        m_z = 1'b0, m_v = 1'b0, m_n = 1'b0;

  ex_sat_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .stall    (stall),
    .flush    (flush),
    .out_valid(out_valid),
    .result   (result),
    .flag_z   (flag_z),
    .flag_v   (flag_v),
    .flag_n   (flag_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".valid"},  {15'b0, out_valid}, {15'b0, m_valid});
    chk({tag, ".result"}, result, m_result);
    chk({tag, ".z"},      {15'b0, flag_z}, {15'b0, m_z});
    chk({tag, ".v"},      {15'b0, flag_v}, {15'b0, m_v});
    chk({tag, ".n"},      {15'b0, flag_n}, {15'b0, m_n});
  endtask

  // Reference: integer arithmetic on true signed values, clamp to 16 bits.
  task automatic model_edge();
    int sa, sb, t;
    logic [15:0] r;
    logic ovf;
    if (flush) begin
      m_valid  = 1'b0;
      m_result = '0;
    end else if (!stall) begin
      if (!in_valid) begin
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b1;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
          2'b00, 2'b01: begin
            t   = (op == 2'b00) ? sa + sb : sa - sb;
            ovf = (t > 32767) || (t < -32768);
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            r = t[15:0];
            m_result = r;
            m_z = (r == 16'h0000);
            m_n = r[15];
            m_v = ovf;
          end
          2'b10: begin
            m_result = a ^ b;
            m_z = ((a ^ b) == 16'h0000);
          end
          default: m_result = b;
        endcase
      end
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [1:0] o,
                      input logic [15:0] aa, input logic [15:0] bb,
                      input logic st, input logic fl);
    in_valid = v; op = o; a = aa; b = bb; stall = st; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
  endtask

  function automatic logic [15:0] pick_operand();
    logic [15:0] tbl [5];
    tbl[0] = 16'h0000; tbl[1] = 16'h0001; tbl[2] = 16'h7FFF;
    tbl[3] = 16'h8000; tbl[4] = 16'hFFFF;
    if ($urandom_range(0, 2) == 0) return tbl[$urandom_range(0, 4)];
    return 16'($urandom);
  endfunction

  initial begin
    // reset state, held across edges
    #2;
    chk_all("reset_async");
    @(posedge clk); #1;
    chk_all("reset_edge");
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset: saturating ADD
    step("add_pos_sat", 1, 2'b00, 16'h7FFF, 16'h0001, 0, 0);
    chk("add_pos_sat.const", {result[15:0]}, 16'h7FFF);
    chk("add_pos_sat.vnz",   {13'b0, flag_v, flag_n, flag_z}, 16'h0004);
    step("sub_neg_sat", 1, 2'b01, 16'h8000, 16'h0001, 0, 0);
    chk("sub_neg_sat.const", result, 16'h8000);
    chk("sub_neg_sat.vnz",   {13'b0, flag_v, flag_n, flag_z}, 16'h0006);
    // XOR updates Z only; V=1,N=1 held
    step("xor_zero", 1, 2'b10, 16'h1234, 16'h1234, 0, 0);
    chk("xor_zero.vnz", {13'b0, flag_v, flag_n, flag_z}, 16'h0007);
    step("passb", 1, 2'b11, 16'h5555, 16'hABCD, 0, 0);
    chk("passb.const", result, 16'hABCD);
    chk("passb.vnz", {13'b0, flag_v, flag_n, flag_z}, 16'h0007);
    step("sub_zero", 1, 2'b01, 16'h0005, 16'h0005, 0, 0);
    chk("sub_zero.vnz", {13'b0, flag_v, flag_n, flag_z}, 16'h0001);
    // SUB of most-negative b: 0 - (-32768) saturates positive
    step("sub_minb", 1, 2'b01, 16'h0000, 16'h8000, 0, 0);
    step("sub_minb2", 1, 2'b01, 16'hFFFF, 16'h8000, 0, 0);
    step("add_neg_sat", 1, 2'b00, 16'h8000, 16'hFFFF, 0, 0);
    // bubble: valid drops, result and flags hold
    step("bubble", 0, 2'b00, 16'h1111, 16'h2222, 0, 0);
    // stall 3 cycles with changing inputs, then capture current inputs
    step("pre_stall", 1, 2'b00, 16'h0100, 16'h0023, 0, 0);
    step("stall0", 1, 2'b01, 16'h7000, 16'h9000, 1, 0);
    step("stall1", 1, 2'b10, 16'hF0F0, 16'h0F0F, 1, 0);
    step("stall2", 0, 2'b00, 16'h7FFF, 16'h7FFF, 1, 0);
    step("post_stall", 1, 2'b00, 16'h4000, 16'h4000, 0, 0);
    chk("post_stall.const", result, 16'h7FFF);
    // flush overrides stall
    step("flush_stall", 1, 2'b00, 16'h0001, 16'h0001, 1, 1);
    chk("flush_stall.const", result, 16'h0000);

    // async reset between edges with out_valid=1 and Z=1
    step("pre_rst", 1, 2'b10, 16'hAAAA, 16'hAAAA, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0; m_result = '0; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
    chk_all("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           pick_operand(), pick_operand(),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
